af_vcm_search: RTL and testbench
================================

# af_vcm_search

Contrast-detect autofocus sequencer for the D8M camera path. It sweeps the lens position in a coarse pass, then a fine pass, and scores each position with a per-frame sharpness metric from the image-statistics stage. For each position it emits a 16-bit VCM command word plus a trigger pulse, which the downstream VCM I2C writer consumes as `VCM_DATA`/`TR_IN`. When the search completes it parks the lens at the best position found.

## Interface
Parameters:
- `POS_MIN`, default 0: lowest lens code, 10-bit.
- `POS_MAX`, default 1023: highest lens code, 10-bit; must be ≥ `POS_MIN`.
- `COARSE_STEP`, default 64: coarse increment; nonzero.
- `FINE_STEP`, default 8: fine increment; nonzero.
- `SETTLE_FRAMES`, default 2: frames discarded after each move, before measuring.
- `TR_HIGH`, default 256: `TR_OUT` high time in `CLK_50` cycles. Must be > 2×125 so the 400 kHz-domain writer samples the edge.
- `STEP_MODE`, default 4'h0: constant placed in `VCM_DATA[3:0]`.

Ports:
- `CLK_50`  in  1: the single clock for the block.
- `RESET_N`  in  1: asynchronous, active-low reset.
- `START`  in  1: one-cycle pulse that begins a search.
- `VS`  in  1: one-cycle end-of-frame strobe; `FOCUS_VALUE` is valid on this cycle.
- `FOCUS_VALUE`  in  24: sharpness metric, unsigned.
- `VCM_DATA`  out  16: VCM command word, `{2'b00, pos[9:0], STEP_MODE}`.
- `TR_OUT`  out  1: trigger for the VCM writer; it acts on the rising edge.
- `BUSY`  out  1: high from accepted `START` until the park move has settled.
- `DONE`  out  1: level; high after completion until the next accepted `START`.
- `BEST_POS`  out  10: best lens code so far.
- `BEST_VALUE`  out  24: metric recorded at `BEST_POS`.
- `ST`  out  4: state code, for test.

## Operation
Reset values:
- `VCM_DATA` = `{2'b00, 10'd0, STEP_MODE}`.
- `TR_OUT`, `BUSY`, `DONE` = 0.
- `BEST_POS`, `BEST_VALUE` = 0.
- `ST` = IDLE.

States:
- **IDLE (0):** on `START`:
  - `BEST_VALUE` ← 0, `BEST_POS` ← `POS_MIN`.
  - pos ← `POS_MIN`, phase ← COARSE.
  - `BUSY` ← 1, `DONE` ← 0.
  - go to MOVE.
- **MOVE (1):** `VCM_DATA` is loaded with pos on entry. `TR_OUT` rises the next cycle and is held `TR_HIGH` cycles, then falls. Clear the frame counter, then go to SETTLE. `VS` is ignored in MOVE.
- **SETTLE (2):** count `VS` strobes. When the count reaches `SETTLE_FRAMES`, go to MEASURE. If `SETTLE_FRAMES` = 0, go to MEASURE immediately.
- **MEASURE (3):** on `VS`:
  - If `FOCUS_VALUE` > `BEST_VALUE` (strictly), then `BEST_VALUE` ← `FOCUS_VALUE` and `BEST_POS` ← pos. Ties keep the earlier position.
  - Go to NEXT.
- **NEXT (4):**
  - If pos == hi, the sweep ends: COARSE goes to FINE_INIT; FINE goes to PARK.
  - Else pos ← min(pos + step, hi) and go to MOVE.
  - For the coarse pass, step = `COARSE_STEP` and hi = `POS_MAX`. The endpoint `POS_MAX` is always visited, even off-grid.
- **FINE_INIT (5):**
  - lo ← max(`BEST_POS` − `COARSE_STEP`, `POS_MIN`).
  - hi ← min(`BEST_POS` + `COARSE_STEP`, `POS_MAX`).
  - Compute in 11 bits signed/unsigned so no wrap occurs.
  - pos ← lo, phase ← FINE, step ← `FINE_STEP`, go to MOVE.
  - `BEST_VALUE` and `BEST_POS` carry over from the coarse pass.
- **PARK (6):** pos ← `BEST_POS`. Issue a MOVE/trigger exactly as in MOVE, then wait `SETTLE_FRAMES` `VS` strobes without measuring, then go to DONE.
- **DONE (7):** `BUSY` = 0, `DONE` = 1. `START` behaves as in IDLE.

Boundary rules:
- `START` while `BUSY` is ignored.
- `START` and `VS` in the same IDLE/DONE cycle: `START` is accepted and that `VS` is not counted.
- `POS_MIN` == `POS_MAX`: each pass visits one position; the search still completes with 3 triggers.
- `RESET_N` low mid-search: all outputs return to reset values at once, and `TR_OUT` drops asynchronously.
- Arithmetic: pos + step is computed in 11 bits and clamped to hi.

## Timing
- `START` to `VCM_DATA` update: 2 cycles (IDLE→MOVE, load on MOVE entry).
- `TR_OUT` rises one cycle after the `VCM_DATA` update. `VCM_DATA` is stable for the whole `TR_OUT` high time and until the next MOVE.
- Minimum spacing between `TR_OUT` rising edges is `TR_HIGH` + 1 + (`SETTLE_FRAMES` + 1) frames.
- A `VS` strobe updates `BEST_*` on the following clock edge.
- Frames per probed position: `SETTLE_FRAMES` + 1.
- The total number of `TR_OUT` pulses is the coarse count + the fine count + 1.

## Test plan
Bench configuration: `POS_MAX`=64, `COARSE_STEP`=16, `FINE_STEP`=4, `SETTLE_FRAMES`=1, `TR_HIGH`=256. The metric model is 1000 − |pos − 40|.

- **Full search:** `START` ->
  - coarse `VCM_DATA` positions 0, 16, 32, 48, 64.
  - the coarse tie between 32 and 48 (both 992) keeps `BEST_POS`=32.
  - fine positions 16, 20, …, 48.
  - park at 40, `VCM_DATA`=16'h0280.
  - `BEST_VALUE`=1000, 15 `TR_OUT` pulses, `DONE`=1.
- **Off-grid endpoint:** `POS_MAX`=70 -> coarse positions 0, 16, 32, 48, 64, 70, and the fine hi clamps to 70 where needed.
- **Low clamp:** metric peaked at 0 -> fine range 0..16, park at 0, `VCM_DATA`=16'h0000.
- **Ignored inputs:** `START` pulsed mid-sweep and `VS` pulsed during MOVE -> neither changes the sequence or the frame counts; each `TR_OUT` high lasts exactly 256 cycles.
- **Reset mid-search:** assert `RESET_N` in MEASURE -> all outputs return to reset values immediately; a following `START` restarts from `POS_MIN`.
- **Restart after completion:** `START` in DONE -> `DONE` drops within 1 cycle, `BEST_VALUE` is cleared, and a new sweep begins.

Source files
------------

// File: rtl/af_vcm_search_if.sv
// Bus bundle for the autofocus sequencer: camera-side inputs, VCM command outputs and status.
// The controller (statistics stage / host) holds the master side, the sequencer the slave side.
interface af_vcm_search_if;
  logic        START;
  logic        VS;
  logic [23:0] FOCUS_VALUE;
  logic [15:0] VCM_DATA;
  logic        TR_OUT;
  logic        BUSY;
  logic        DONE;
  logic [9:0]  BEST_POS;
  logic [23:0] BEST_VALUE;
  logic [3:0]  ST;

  modport master (
    output START, VS, FOCUS_VALUE,
    input  VCM_DATA, TR_OUT, BUSY, DONE, BEST_POS, BEST_VALUE, ST
  );

  modport slave (
    input  START, VS, FOCUS_VALUE,
    output VCM_DATA, TR_OUT, BUSY, DONE, BEST_POS, BEST_VALUE, ST
  );
endinterface

// File: rtl/af_vcm_search.sv
// Contrast-detect autofocus sequencer: coarse sweep, fine sweep around the coarse peak, then park
// at the sharpest lens code. Each probed position gets one VCM command word and trigger pulse.
module af_vcm_search #(
  parameter int unsigned POS_MIN       = 0,
  parameter int unsigned POS_MAX       = 1023,
  parameter int unsigned COARSE_STEP   = 64,
  parameter int unsigned FINE_STEP     = 8,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned TR_HIGH       = 256,
  parameter logic [3:0]  STEP_MODE     = 4'h0
) (
  input logic              CLK_50,
  input logic              RESET_N,
  af_vcm_search_if.slave   bus
);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StMove     = 4'd1;
  localparam logic [3:0] StSettle   = 4'd2;
  localparam logic [3:0] StMeasure  = 4'd3;
  localparam logic [3:0] StNext     = 4'd4;
  localparam logic [3:0] StFineInit = 4'd5;
  localparam logic [3:0] StPark     = 4'd6;
  localparam logic [3:0] StDone     = 4'd7;

  localparam logic [1:0] PhCoarse = 2'd0;
  localparam logic [1:0] PhFine   = 2'd1;
  localparam logic [1:0] PhPark   = 2'd2;

  localparam int unsigned TrCntW  = $clog2(TR_HIGH + 2) + 1;
  localparam int unsigned FrmCntW = $clog2(SETTLE_FRAMES + 1) + 1;

  localparam logic [TrCntW-1:0]  TrLast     = TrCntW'(TR_HIGH + 1);
  localparam logic [FrmCntW-1:0] SettleLast = FrmCntW'(SETTLE_FRAMES);
  localparam logic [11:0]        PosMin12   = 12'(POS_MIN);
  localparam logic [11:0]        PosMax12   = 12'(POS_MAX);
  localparam logic [11:0]        Coarse12   = 12'(COARSE_STEP);
  localparam logic [11:0]        Fine12     = 12'(FINE_STEP);
  localparam logic [9:0]         PosMin10   = 10'(POS_MIN);
  localparam logic [9:0]         PosMax10   = 10'(POS_MAX);
  localparam logic [9:0]         Coarse10   = 10'(COARSE_STEP);

  logic [3:0]         st_q, st_d;
  logic [1:0]         phase_q, phase_d;
  logic [9:0]         pos_q, pos_d;
  logic [9:0]         hi_q, hi_d;
  logic [TrCntW-1:0]  tr_cnt_q, tr_cnt_d;
  logic [FrmCntW-1:0] frm_cnt_q, frm_cnt_d;
  logic [15:0]        vcm_data_q, vcm_data_d;
  logic               tr_q, tr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [9:0]         best_pos_q, best_pos_d;
  logic [23:0]        best_val_q, best_val_d;

  logic [11:0] step12, sum12, best_ext, hi_ext;
  logic [9:0]  pos_inc, fine_lo, fine_hi;
  logic [3:0]  settle_exit;

  always_comb begin
    // Widened to 12 bits so pos + step and best +/- step never wrap before clamping.
    step12   = (phase_q == PhFine) ? Fine12 : Coarse12;
    sum12    = {2'b00, pos_q} + step12;
    pos_inc  = (sum12 > {2'b00, hi_q}) ? hi_q : sum12[9:0];
    best_ext = {2'b00, best_pos_q};
    hi_ext   = best_ext + Coarse12;
    fine_lo  = (best_ext < PosMin12 + Coarse12) ? PosMin10 : (best_pos_q - Coarse10);
    fine_hi  = (hi_ext > PosMax12) ? PosMax10 : hi_ext[9:0];
    settle_exit = (phase_q == PhPark) ? StDone : StMeasure;
  end

  always_comb begin
    st_d       = st_q;
    phase_d    = phase_q;
    pos_d      = pos_q;
    hi_d       = hi_q;
    tr_cnt_d   = tr_cnt_q;
    frm_cnt_d  = frm_cnt_q;
    vcm_data_d = vcm_data_q;
    tr_d       = tr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    best_pos_d = best_pos_q;
    best_val_d = best_val_q;

    case (st_q)
      StIdle, StDone: begin
        if (bus.START) begin
          best_val_d = '0;
          best_pos_d = PosMin10;
          pos_d      = PosMin10;
          hi_d       = PosMax10;
          phase_d    = PhCoarse;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          st_d       = StMove;
        end
      end
      StMove: begin
        // Count 0 loads the command, count 1 raises the trigger, TrLast drops it.
        if (tr_cnt_q == '0) begin
          vcm_data_d = {2'b00, pos_q, STEP_MODE};
          tr_cnt_d   = tr_cnt_q + 1'b1;
        end else if (tr_cnt_q == TrLast) begin
          tr_d      = 1'b0;
          tr_cnt_d  = '0;
          frm_cnt_d = '0;
          st_d      = StSettle;
        end else begin
          if (tr_cnt_q == TrCntW'(1)) tr_d = 1'b1;
          tr_cnt_d = tr_cnt_q + 1'b1;
        end
      end
      StSettle: begin
        if (SETTLE_FRAMES == 0) begin
          st_d = settle_exit;
        end else if (bus.VS) begin
          if (frm_cnt_q + 1'b1 == SettleLast) st_d = settle_exit;
          else frm_cnt_d = frm_cnt_q + 1'b1;
        end
        if (st_d == StDone) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      StMeasure: begin
        if (bus.VS) begin
          if (bus.FOCUS_VALUE > best_val_q) begin
            best_val_d = bus.FOCUS_VALUE;
            best_pos_d = pos_q;
          end
          st_d = StNext;
        end
      end
      StNext: begin
        if (pos_q == hi_q) begin
          st_d = (phase_q == PhCoarse) ? StFineInit : StPark;
        end else begin
          pos_d = pos_inc;
          st_d  = StMove;
        end
      end
      StFineInit: begin
        pos_d   = fine_lo;
        hi_d    = fine_hi;
        phase_d = PhFine;
        st_d    = StMove;
      end
      StPark: begin
        pos_d   = best_pos_q;
        phase_d = PhPark;
        st_d    = StMove;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      st_q       <= StIdle;
      phase_q    <= PhCoarse;
      pos_q      <= '0;
      hi_q       <= '0;
      tr_cnt_q   <= '0;
      frm_cnt_q  <= '0;
      vcm_data_q <= {2'b00, 10'd0, STEP_MODE};
      tr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      best_pos_q <= '0;
      best_val_q <= '0;
    end else begin
      st_q       <= st_d;
      phase_q    <= phase_d;
      pos_q      <= pos_d;
      hi_q       <= hi_d;
      tr_cnt_q   <= tr_cnt_d;
      frm_cnt_q  <= frm_cnt_d;
      vcm_data_q <= vcm_data_d;
      tr_q       <= tr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      best_pos_q <= best_pos_d;
      best_val_q <= best_val_d;
    end
  end

  assign bus.VCM_DATA   = vcm_data_q;
  assign bus.TR_OUT     = tr_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.BEST_POS   = best_pos_q;
  assign bus.BEST_VALUE = best_val_q;
  assign bus.ST         = st_q;

endmodule

// File: tb/tb_af_vcm_search.sv
// Directed bench for af_vcm_search: a free-running frame strobe plays the camera, a monitor logs
// each trigger pulse, and per-scenario tasks compare the log against hand-computed sweeps.
module tb_af_vcm_search;
  logic clk, rst_n, start_a, start_b, vs_per, vs_extra, sel;
  int   model_sel, errors, checks;
  int   rise_pos[$], best_at_rise[$], gap_vs[$], high_len[$];
  int   vs_since_fall, vcm_unstable;

  logic        tr_m, busy_m, done_m, vs_m, start_m;
  logic [15:0] vcm_m;
  logic [9:0]  bpos_m;
  logic [23:0] bval_m;
  logic [3:0]  st_m;

  af_vcm_search_if bus_a ();
  af_vcm_search_if bus_b ();

  // Lens metric models: 0 peaks at 40, 1 peaks at 70, 2 peaks at 0.
  function automatic logic [23:0] metric(input logic [9:0] p, input int m);
    int d;
    int pi;
    pi = int'(p);
    case (m)
      0:       d = (pi > 40) ? pi - 40 : 40 - pi;
      1:       d = (pi > 70) ? pi - 70 : 70 - pi;
      default: d = pi;
    endcase
    return 24'(1000 - d);
  endfunction

  assign bus_a.START       = start_a;
  assign bus_a.VS          = vs_per | vs_extra;
  assign bus_a.FOCUS_VALUE = vs_extra ? 24'hFFFFFF : metric(bus_a.VCM_DATA[13:4], model_sel);
  assign bus_b.START       = start_b;
  assign bus_b.VS          = vs_per | vs_extra;
  assign bus_b.FOCUS_VALUE = vs_extra ? 24'hFFFFFF : metric(bus_b.VCM_DATA[13:4], model_sel);

  af_vcm_search #(.POS_MAX(64), .COARSE_STEP(16), .FINE_STEP(4), .SETTLE_FRAMES(1),
                  .TR_HIGH(256)) dut_a (.CLK_50(clk), .RESET_N(rst_n), .bus(bus_a));
  af_vcm_search #(.POS_MAX(70), .COARSE_STEP(16), .FINE_STEP(4), .SETTLE_FRAMES(1),
                  .TR_HIGH(256)) dut_b (.CLK_50(clk), .RESET_N(rst_n), .bus(bus_b));

  assign tr_m    = sel ? bus_b.TR_OUT     : bus_a.TR_OUT;
  assign busy_m  = sel ? bus_b.BUSY       : bus_a.BUSY;
  assign done_m  = sel ? bus_b.DONE       : bus_a.DONE;
  assign vs_m    = sel ? bus_b.VS         : bus_a.VS;
  assign start_m = sel ? bus_b.START      : bus_a.START;
  assign vcm_m   = sel ? bus_b.VCM_DATA   : bus_a.VCM_DATA;
  assign bpos_m  = sel ? bus_b.BEST_POS   : bus_a.BEST_POS;
  assign bval_m  = sel ? bus_b.BEST_VALUE : bus_a.BEST_VALUE;
  assign st_m    = sel ? bus_b.ST         : bus_a.ST;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int cnt;
    cnt    = 0;
    vs_per = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cnt    = (cnt == 63) ? 0 : cnt + 1;
      vs_per = (cnt == 0);
    end
  end

  initial begin
    logic        tr_prev;
    logic        have_fall;
    int          high_cnt;
    logic [15:0] vcm_at_rise;
    tr_prev = 1'b0; have_fall = 1'b0; high_cnt = 0; vcm_at_rise = '0;
    vs_since_fall = 0; vcm_unstable = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tr_prev = 1'b0; have_fall = 1'b0; high_cnt = 0; vs_since_fall = 0;
      end else begin
        if (start_m && !busy_m) have_fall = 1'b0;
        if (tr_m && !tr_prev) begin
          rise_pos.push_back(int'(vcm_m[13:4]));
          best_at_rise.push_back(int'(bpos_m));
          gap_vs.push_back(have_fall ? vs_since_fall : -1);
          high_cnt    = 0;
          vcm_at_rise = vcm_m;
        end
        if (tr_m) begin
          high_cnt++;
          if (vcm_m !== vcm_at_rise) vcm_unstable++;
        end
        if (!tr_m && tr_prev) begin
          high_len.push_back(high_cnt);
          have_fall     = 1'b1;
          vs_since_fall = 0;
        end
        if (!tr_m && vs_m) vs_since_fall++;
        tr_prev = tr_m;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_start(input logic which);
    @(posedge clk); #1;
    if (which) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_m && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done_m !== 1'b1) begin
      errors++;
      $display("FAIL %s done timeout: got DONE=%0b, required 1", tag, done_m);
    end
  endtask

  task automatic wait_rises(input int target, input string tag);
    int n = 0;
    while (rise_pos.size() < target && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (rise_pos.size() < target) begin
      errors++;
      $display("FAIL %s trigger timeout: got %0d pulses, required %0d", tag, rise_pos.size(),
               target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 8;
    if (bus_a.VCM_DATA !== 16'h0000) begin errors++;
      $display("FAIL reset VCM_DATA: got %h, required 0000", bus_a.VCM_DATA); end
    if (bus_a.TR_OUT !== 1'b0) begin errors++;
      $display("FAIL reset TR_OUT: got %b, required 0", bus_a.TR_OUT); end
    if (bus_a.BUSY !== 1'b0) begin errors++;
      $display("FAIL reset BUSY: got %b, required 0", bus_a.BUSY); end
    if (bus_a.DONE !== 1'b0) begin errors++;
      $display("FAIL reset DONE: got %b, required 0", bus_a.DONE); end
    if (bus_a.BEST_POS !== 10'd0) begin errors++;
      $display("FAIL reset BEST_POS: got %0d, required 0", bus_a.BEST_POS); end
    if (bus_a.BEST_VALUE !== 24'd0) begin errors++;
      $display("FAIL reset BEST_VALUE: got %0d, required 0", bus_a.BEST_VALUE); end
    if (bus_a.ST !== 4'd0) begin errors++;
      $display("FAIL reset ST: got %0d, required 0", bus_a.ST); end
    if (bus_b.VCM_DATA !== 16'h0000) begin errors++;
      $display("FAIL reset VCM_DATA b: got %h, required 0000", bus_b.VCM_DATA); end
    rst_n = 1'b1;
  endtask

  task automatic test_full_search();
    int exp[15] = '{0, 16, 32, 48, 64, 16, 20, 24, 28, 32, 36, 40, 44, 48, 40};
    int base, hbase, unst, got;
    sel = 1'b0; model_sel = 0;
    base = rise_pos.size(); hbase = high_len.size(); unst = vcm_unstable;
    pulse_start(1'b0);
    checks += 3;
    if (st_m !== 4'd1) begin errors++; $display("FAIL full ST after START: got %0d, required 1", st_m); end
    if (busy_m !== 1'b1) begin errors++; $display("FAIL full BUSY: got %b, required 1", busy_m); end
    if (tr_m !== 1'b0) begin errors++; $display("FAIL full TR early: got %b, required 0", tr_m); end
    @(posedge clk); #1;
    checks++;
    if (tr_m !== 1'b0) begin errors++; $display("FAIL full TR at load: got %b, required 0", tr_m); end
    @(posedge clk); #1;
    checks++;
    if (tr_m !== 1'b1) begin errors++; $display("FAIL full TR rise: got %b, required 1", tr_m); end
    wait_done("full");
    checks += 7;
    if (rise_pos.size() - base !== 15) begin errors++;
      $display("FAIL full pulse count: got %0d, required 15", rise_pos.size() - base); end
    if (bpos_m !== 10'd40) begin errors++; $display("FAIL full BEST_POS: got %0d, required 40", bpos_m); end
    if (bval_m !== 24'd1000) begin errors++;
      $display("FAIL full BEST_VALUE: got %0d, required 1000", bval_m); end
    if (vcm_m !== 16'h0280) begin errors++; $display("FAIL full park VCM_DATA: got %h, required 0280", vcm_m); end
    if (busy_m !== 1'b0) begin errors++; $display("FAIL full BUSY end: got %b, required 0", busy_m); end
    if (vs_since_fall !== 1) begin errors++;
      $display("FAIL full park settle frames: got %0d, required 1", vs_since_fall); end
    if (vcm_unstable !== unst) begin errors++;
      $display("FAIL full VCM_DATA stability: got %0d changes, required 0", vcm_unstable - unst); end
    for (int i = 0; i < 15; i++) begin
      got = (base + i < rise_pos.size()) ? rise_pos[base + i] : -1;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL full pos[%0d]: got %0d, required %0d", i, got, exp[i]); end
      got = (hbase + i < high_len.size()) ? high_len[hbase + i] : -1;
      checks++;
      if (got !== 256) begin errors++; $display("FAIL full TR high[%0d]: got %0d, required 256", i, got); end
      if (i > 0) begin
        got = (base + i < gap_vs.size()) ? gap_vs[base + i] : -1;
        checks++;
        if (got !== 2) begin errors++; $display("FAIL full frames[%0d]: got %0d, required 2", i, got); end
      end
    end
    got = (base + 5 < best_at_rise.size()) ? best_at_rise[base + 5] : -1;
    checks++;
    if (got !== 32) begin errors++; $display("FAIL full coarse tie BEST_POS: got %0d, required 32", got); end
  endtask

  task automatic test_off_grid();
    int exp[12] = '{0, 16, 32, 48, 64, 70, 54, 58, 62, 66, 70, 70};
    int base, got;
    sel = 1'b1; model_sel = 1;
    base = rise_pos.size();
    pulse_start(1'b1);
    wait_done("offgrid");
    checks += 4;
    if (rise_pos.size() - base !== 12) begin errors++;
      $display("FAIL offgrid pulse count: got %0d, required 12", rise_pos.size() - base); end
    if (bpos_m !== 10'd70) begin errors++; $display("FAIL offgrid BEST_POS: got %0d, required 70", bpos_m); end
    if (bval_m !== 24'd1000) begin errors++;
      $display("FAIL offgrid BEST_VALUE: got %0d, required 1000", bval_m); end
    if (vcm_m !== 16'h0460) begin errors++; $display("FAIL offgrid park VCM_DATA: got %h, required 0460", vcm_m); end
    for (int i = 0; i < 12; i++) begin
      got = (base + i < rise_pos.size()) ? rise_pos[base + i] : -1;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL offgrid pos[%0d]: got %0d, required %0d", i, got, exp[i]); end
    end
    sel = 1'b0;
  endtask

  task automatic test_low_clamp();
    int exp[11] = '{0, 16, 32, 48, 64, 0, 4, 8, 12, 16, 0};
    int base, got;
    sel = 1'b0; model_sel = 2;
    base = rise_pos.size();
    pulse_start(1'b0);
    wait_done("lowclamp");
    checks += 4;
    if (rise_pos.size() - base !== 11) begin errors++;
      $display("FAIL lowclamp pulse count: got %0d, required 11", rise_pos.size() - base); end
    if (bpos_m !== 10'd0) begin errors++; $display("FAIL lowclamp BEST_POS: got %0d, required 0", bpos_m); end
    if (bval_m !== 24'd1000) begin errors++;
      $display("FAIL lowclamp BEST_VALUE: got %0d, required 1000", bval_m); end
    if (vcm_m !== 16'h0000) begin errors++; $display("FAIL lowclamp park VCM_DATA: got %h, required 0000", vcm_m); end
    for (int i = 0; i < 11; i++) begin
      got = (base + i < rise_pos.size()) ? rise_pos[base + i] : -1;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL lowclamp pos[%0d]: got %0d, required %0d", i, got, exp[i]); end
    end
  endtask

  task automatic test_ignored_inputs();
    int exp[15] = '{0, 16, 32, 48, 64, 16, 20, 24, 28, 32, 36, 40, 44, 48, 40};
    int base, hbase, got;
    sel = 1'b0; model_sel = 0;
    base = rise_pos.size(); hbase = high_len.size();
    pulse_start(1'b0);
    wait_rises(base + 3, "ignored");
    repeat (10) @(posedge clk);
    #1 vs_extra = 1'b1;
    @(posedge clk); #1 vs_extra = 1'b0; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    while (tr_m) begin @(posedge clk); #1; end
    repeat (5) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done("ignored");
    checks += 3;
    if (rise_pos.size() - base !== 15) begin errors++;
      $display("FAIL ignored pulse count: got %0d, required 15", rise_pos.size() - base); end
    if (bval_m !== 24'd1000) begin errors++;
      $display("FAIL ignored BEST_VALUE: got %0d, required 1000", bval_m); end
    if (bpos_m !== 10'd40) begin errors++; $display("FAIL ignored BEST_POS: got %0d, required 40", bpos_m); end
    for (int i = 0; i < 15; i++) begin
      got = (base + i < rise_pos.size()) ? rise_pos[base + i] : -1;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL ignored pos[%0d]: got %0d, required %0d", i, got, exp[i]); end
      got = (hbase + i < high_len.size()) ? high_len[hbase + i] : -1;
      checks++;
      if (got !== 256) begin errors++; $display("FAIL ignored TR high[%0d]: got %0d, required 256", i, got); end
      if (i > 0) begin
        got = (base + i < gap_vs.size()) ? gap_vs[base + i] : -1;
        checks++;
        if (got !== 2) begin errors++; $display("FAIL ignored frames[%0d]: got %0d, required 2", i, got); end
      end
    end
  endtask

  task automatic test_reset_mid_search();
    int base, n, got;
    sel = 1'b0; model_sel = 0;
    base = rise_pos.size();
    pulse_start(1'b0);
    wait_rises(base + 3, "midreset");
    n = 0;
    while (st_m !== 4'd3 && n < 2000) begin @(posedge clk); #1; n++; end
    checks++;
    if (st_m !== 4'd3) begin errors++; $display("FAIL midreset reach MEASURE: got %0d, required 3", st_m); end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checks += 7;
    if (vcm_m !== 16'h0000) begin errors++; $display("FAIL midreset VCM_DATA: got %h, required 0000", vcm_m); end
    if (tr_m !== 1'b0) begin errors++; $display("FAIL midreset TR_OUT: got %b, required 0", tr_m); end
    if (busy_m !== 1'b0) begin errors++; $display("FAIL midreset BUSY: got %b, required 0", busy_m); end
    if (done_m !== 1'b0) begin errors++; $display("FAIL midreset DONE: got %b, required 0", done_m); end
    if (bpos_m !== 10'd0) begin errors++; $display("FAIL midreset BEST_POS: got %0d, required 0", bpos_m); end
    if (bval_m !== 24'd0) begin errors++; $display("FAIL midreset BEST_VALUE: got %0d, required 0", bval_m); end
    if (st_m !== 4'd0) begin errors++; $display("FAIL midreset ST: got %0d, required 0", st_m); end
    @(negedge clk); @(posedge clk); #1 rst_n = 1'b1;
    base = rise_pos.size();
    pulse_start(1'b0);
    wait_rises(base + 2, "midreset restart");
    got = (base < rise_pos.size()) ? rise_pos[base] : -1;
    checks++;
    if (got !== 0) begin errors++; $display("FAIL midreset restart pos0: got %0d, required 0", got); end
    got = (base + 1 < rise_pos.size()) ? rise_pos[base + 1] : -1;
    checks++;
    if (got !== 16) begin errors++; $display("FAIL midreset restart pos1: got %0d, required 16", got); end
    checks++;
    if (tr_m !== 1'b1) begin errors++; $display("FAIL midreset TR before async: got %b, required 1", tr_m); end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (tr_m !== 1'b0) begin errors++; $display("FAIL midreset async TR_OUT: got %b, required 0", tr_m); end
    if (st_m !== 4'd0) begin errors++; $display("FAIL midreset async ST: got %0d, required 0", st_m); end
    @(negedge clk); @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_restart();
    int base, got;
    sel = 1'b0; model_sel = 0;
    base = rise_pos.size();
    pulse_start(1'b0);
    wait_done("restart first");
    checks += 2;
    if (rise_pos.size() - base !== 15) begin errors++;
      $display("FAIL restart first pulse count: got %0d, required 15", rise_pos.size() - base); end
    if (bval_m !== 24'd1000) begin errors++;
      $display("FAIL restart first BEST_VALUE: got %0d, required 1000", bval_m); end
    base = rise_pos.size();
    pulse_start(1'b0);
    checks += 5;
    if (done_m !== 1'b0) begin errors++; $display("FAIL restart DONE drop: got %b, required 0", done_m); end
    if (busy_m !== 1'b1) begin errors++; $display("FAIL restart BUSY: got %b, required 1", busy_m); end
    if (bval_m !== 24'd0) begin errors++; $display("FAIL restart BEST_VALUE clear: got %0d, required 0", bval_m); end
    if (st_m !== 4'd1) begin errors++; $display("FAIL restart ST: got %0d, required 1", st_m); end
    if (vcm_m !== 16'h0280) begin errors++; $display("FAIL restart VCM early: got %h, required 0280", vcm_m); end
    @(posedge clk); #1;
    checks++;
    if (vcm_m !== 16'h0000) begin errors++; $display("FAIL restart VCM load: got %h, required 0000", vcm_m); end
    wait_rises(base + 2, "restart");
    got = (base + 1 < rise_pos.size()) ? rise_pos[base + 1] : -1;
    checks++;
    if (got !== 16) begin errors++; $display("FAIL restart second pos: got %0d, required 16", got); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; vs_extra = 1'b0;
    sel = 1'b0; model_sel = 0;
    test_reset();
    test_full_search();
    test_off_grid();
    test_low_clamp();
    test_ignored_inputs();
    test_reset_mid_search();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
